// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch stage for a 5-stage RV32I pipeline. It owns the fetch PC,
// issues in-order word requests to instruction memory and buffers the
// returned words in a DEPTH-entry prefetch queue. The queue head is offered
// to decode as {pc, npc, ir} with a valid/ready handshake.
//
// A redirect from EX flushes the queue, reloads the fetch PC and counts the
// responses still in flight so they are discarded when they arrive.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target enters FAULT and raises
//               the sticky fetch_fault flag until rst or an aligned redirect.
//   undefined : the low two target bits are ignored; fetch_fault is always 0.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous reset, active-high
//   imem_req_valid out  fetch request valid
//   imem_req_addr  out  word-aligned fetch address
//   imem_req_ready in   memory accepts the request this cycle
//   imem_rsp_valid in   in-order response valid
//   imem_rsp_data  in   fetched instruction word
//   redirect_valid in   EX-stage control transfer (one-cycle pulse)
//   redirect_pc    in   control-transfer target
//   id_valid       out  queue head valid towards decode
//   id_ready       in   decode consumes the head this cycle
//   id_pc          out  PC of the head instruction
//   id_npc         out  id_pc + 4
//   id_ir          out  head instruction word
//   fetch_fault    out  misaligned redirect seen (trap build only)
// -----------------------------------------------------------------------------
module if_prefetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_npc,
    output logic [DATA_WIDTH-1:0] id_ir,
    output logic                  fetch_fault
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]           DEPTH_LIM = (CW+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] WORD_STEP = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DROP  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t                state, state_nxt;

    logic [DATA_WIDTH-1:0] fetch_pc;
    // PC of the oldest response that will be kept; it tags words on push.
    logic [DATA_WIDTH-1:0] rsp_pc;

    logic [DATA_WIDTH-1:0] q_pc [DEPTH];
    logic [DATA_WIDTH-1:0] q_ir [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_cnt;

    logic [CW:0]           in_use;
    logic [CW-1:0]         drop_load;
    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  req_fire;
    logic                  rsp_discard;
    logic                  push;
    logic                  pop;
    logic                  misaligned;

    // ------------------------------------------------------------------
    // Request side: one credit per queue slot, counting words already
    // buffered plus words still on their way back from memory.
    // ------------------------------------------------------------------
    assign in_use         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && (state != FAULT) && (in_use < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // ------------------------------------------------------------------
    // Response side. A word arriving in the redirect cycle belongs to the
    // old stream and is discarded along with the counted stale ones.
    // ------------------------------------------------------------------
    assign rsp_discard = (drop_cnt != '0) || (state == FAULT) || redirect_valid;
    assign push        = imem_rsp_valid && !rsp_discard;

    // ------------------------------------------------------------------
    // Decode side. Outputs read as zero while the queue is empty so the
    // unreset queue storage never leaks onto id_*.
    // ------------------------------------------------------------------
    assign id_valid = (count != '0) && (state != FAULT);
    assign pop      = id_valid && id_ready && !redirect_valid;
    assign id_pc    = id_valid ? q_pc[rd_ptr] : '0;
    assign id_npc   = id_valid ? q_pc[rd_ptr] + WORD_STEP : '0;
    assign id_ir    = id_valid ? q_ir[rd_ptr] : '0;

    // Responses still owed by memory after this cycle; all of them are stale
    // once a redirect is taken.
    assign drop_load       = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    assign redirect_target = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
    assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_fault = (state == FAULT);
`else
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^redirect_pc[1:0];
    assign misaligned     = 1'b0;
    assign fetch_fault    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            if (misaligned) begin
                state_nxt = FAULT;
            end else if (drop_load != '0) begin
                state_nxt = DROP;
            end else begin
                state_nxt = RUN;
            end
        end else begin
            case (state)
                DROP: begin
                    if (drop_cnt == '0 ||
                        (imem_rsp_valid && drop_cnt == CW'(1))) begin
                        state_nxt = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            outstanding <= drop_load;

            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + WORD_STEP;
            end

            if (redirect_valid) begin
                rsp_pc <= redirect_target;
            end else if (push) begin
                rsp_pc <= rsp_pc + WORD_STEP;
            end

            if (redirect_valid) begin
                drop_cnt <= drop_load;
            end else if (imem_rsp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    // NOTE: the queue array carries no reset; count gates every read, so
    // stale contents are never observed and the storage can map to plain
    // registers or RAM without reset wiring.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr] <= rsp_pc;
            q_ir[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_unit
//
// Bench for if_prefetch_unit. A behavioural instruction memory answers
// accepted requests in order after a configurable latency. The reference
// model keeps the in-flight requests and the deliverable instruction stream
// as queues tagged with a redirect epoch: words fetched before a redirect
// belong to an older epoch and must never reach decode.
// -----------------------------------------------------------------------------
module tb_if_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_npc;
    logic [31:0] id_ir;
    logic        fetch_fault;

    if_prefetch_unit #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_npc         (id_npc),
        .id_ir          (id_ir),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        pending[$];   // accepted by memory, response not yet given
    logic [31:0] avail[$];     // current-epoch words waiting for decode
    int          cyc;
    int          epoch;
    int          lat_min;
    int          lat_max;
    logic [31:0] exp_req_addr;
    logic        faulted;

    int vectors;
    int miscompares;

    // Outputs sampled in the most recent step
    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_id_valid;
    logic [31:0] s_id_pc;
    logic [31:0] s_id_npc;
    logic [31:0] s_id_ir;
    logic        s_fault;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        // NOTE: stimulus is driven with blocking assignments away from the
        // clock edge, so the DUT sees settled values at every posedge.
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        @(posedge clk);
        #1;
        check("rst req_valid",   {31'b0, imem_req_valid}, 32'h0);
        check("rst id_valid",    {31'b0, id_valid},       32'h0);
        check("rst id_pc",       id_pc,                   32'h0);
        check("rst id_npc",      id_npc,                  32'h0);
        check("rst id_ir",       id_ir,                   32'h0);
        check("rst fetch_fault", {31'b0, fetch_fault},    32'h0);
        rst = 1'b0;
        pending.delete();
        avail.delete();
        epoch        = 0;
        cyc          = 0;
        exp_req_addr = 32'h0;
        faulted      = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance
    // the model by what happens at the coming edge.
    task automatic step(input logic rdy, input logic idr, input logic rv,
                        input logic [31:0] rpc, input logic rsp_en);
        logic        rsp;
        logic        exp_rv;
        logic        model_valid;
        logic [31:0] head;
        req_t        r;
        @(negedge clk);
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rsp            = rsp_en && (pending.size() > 0) && (pending[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word(pending[0].addr) : 32'hDEAD_BEEF;
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_npc    = id_npc;
        s_id_ir     = id_ir;
        s_fault     = fetch_fault;

        exp_rv = !faulted && ((pending.size() + avail.size()) < DEPTH);
        check("req_valid", {31'b0, s_req_valid}, {31'b0, exp_rv});
        if (s_req_valid && exp_rv) check("req_addr", s_req_addr, exp_req_addr);
        model_valid = (avail.size() != 0);
        check("id_valid", {31'b0, s_id_valid}, {31'b0, model_valid});
        if (model_valid) begin
            head = avail[0];
            check("id_pc",  s_id_pc,  head);
            check("id_npc", s_id_npc, head + 32'd4);
            check("id_ir",  s_id_ir,  word(head));
        end
        check("fetch_fault", {31'b0, s_fault}, {31'b0, faulted});

        if (model_valid && idr && !rv) void'(avail.pop_front());
        if (rsp) begin
            r = pending.pop_front();
            if (r.epoch == epoch && !rv && !faulted) avail.push_back(r.addr);
        end
        if (s_req_valid && rdy) begin
            pending.push_back('{s_req_addr, cyc + int'($urandom_range(lat_min, lat_max)), epoch});
            exp_req_addr = exp_req_addr + 32'd4;
        end
        if (rv) begin
            avail.delete();
            epoch++;
            exp_req_addr = {rpc[31:2], 2'b00};
`ifdef IF_MISALIGN_TRAP_EN
            faulted = (rpc[1:0] != 2'b00);
`endif
        end
        @(posedge clk);
        cyc++;
    endtask

    // Run until decode sees a valid head, then compare its PC.
    task automatic wait_first_pc(input string name, input logic [31:0] target);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            if (s_id_valid) seen = 1'b1;
        end
        check({name, " reached"}, {31'b0, seen}, 32'h1);
        if (seen) check({name, " first pc"}, s_id_pc, target);
    endtask

    // ------------------------------------------------------------------
    // Directed table: reset, streaming, decode stall, memory stall.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rdy;
        logic        idr;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ip;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        lat_min     = 1;
        lat_max     = 1;
        cyc         = 0;
        epoch       = 0;
        faulted     = 1'b0;

        // streaming with latency 1: id_pc trails the request address by 8
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
        // decode stalls: credits run out once the queue holds DEPTH words
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd28, 1'b1, 32'd16};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 32'd16};
        // release: back-to-back pops, credit returns one cycle after a pop
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 32'd16};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'd40, 1'b1, 32'd28};
        // memory stalls at 0x2c: address held, queue drains
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'd44, 1'b1, 32'd32};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'd44, 1'b1, 32'd36};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 32'd44, 1'b1, 32'd40};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'd44, 1'b0, 32'd0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 32'd44, 1'b0, 32'd0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 32'd48, 1'b0, 32'd0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 32'd52, 1'b1, 32'd44};

        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        do_reset();
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rdy, vecs[i].idr, 1'b0, 32'h0, 1'b1);
            check($sformatf("tbl[%0d] req_valid", i), {31'b0, s_req_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv) check($sformatf("tbl[%0d] req_addr", i), s_req_addr, vecs[i].e_ra);
            check($sformatf("tbl[%0d] id_valid", i), {31'b0, s_id_valid}, {31'b0, vecs[i].e_iv});
            if (vecs[i].e_iv) begin
                check($sformatf("tbl[%0d] id_pc", i),  s_id_pc,  vecs[i].e_ip);
                check($sformatf("tbl[%0d] id_npc", i), s_id_npc, vecs[i].e_ip + 32'd4);
                check($sformatf("tbl[%0d] id_ir", i),  s_id_ir,  word(vecs[i].e_ip));
            end
        end

        // Redirect with several responses in flight (latency 3).
        lat_min = 3;
        lat_max = 3;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h100, 1'b1);
        wait_first_pc("redirect_inflight", 32'h100);

        // Redirect coinciding with pop, push and request acceptance.
        lat_min = 1;
        lat_max = 1;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("redirect_busy queue empty", {31'b0, s_id_valid}, 32'h0);
        wait_first_pc("redirect_busy", 32'h300);

        // Fetch PC wraps past the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        wait_first_pc("wrap", 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect target.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h102, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef IF_MISALIGN_TRAP_EN
        check("misalign fault",     {31'b0, s_fault},     32'h1);
        check("misalign req_valid", {31'b0, s_req_valid}, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        check("fault exit flag",      {31'b0, s_fault},     32'h0);
        check("fault exit req_valid", {31'b0, s_req_valid}, 32'h1);
        check("fault exit req_addr",  s_req_addr,           32'h200);
        wait_first_pc("fault exit", 32'h200);
`else
        check("misalign fault",     {31'b0, s_fault},     32'h0);
        check("misalign req_valid", {31'b0, s_req_valid}, 32'h1);
        check("misalign req_addr",  s_req_addr,           32'h100);
        wait_first_pc("misalign", 32'h100);
`endif

        // Randomized traffic against the model, with a reset mid-run.
        lat_min = 1;
        lat_max = 4;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        rv;
            logic [31:0] tgt;
            if (i == 1500) do_reset();
            rv  = ($urandom_range(0, 19) == 0);
            tgt = $urandom & 32'h0000_FFFC;
`ifndef IF_MISALIGN_TRAP_EN
            tgt = tgt | 32'($urandom_range(0, 3));
`endif
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rv, tgt,
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
